// File: rtl/mips_mem_pkg.sv
// Shared encodings for the CPU data-memory interface: access sizes,
// MIPS exception codes, LSU state enum and the alignment check.
package mips_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_t;

  // Size 11 has no legal alignment, so it is always reported misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = |addr_lo;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: byte enables and replicated store data
// for the outgoing bus, plus lane extraction and sign/zero extension of
// returned load data.
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Lane selection and extension for the current access size.
  always_comb begin
    be         = '0;
    lane_wdata = '0;
    load_data  = '0;
    shifted    = rdata >> {addr_lo, 3'b000};
    case (size)
      SIZE_BYTE: begin
        be         = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        load_data  = {{24{sign & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        be         = 4'b0011 << addr_lo;
        lane_wdata = {2{wdata[15:0]}};
        load_data  = {{16{sign & shifted[15]}}, shifted[15:0]};
      end
      SIZE_WORD: begin
        be         = 4'b1111;
        lane_wdata = wdata;
        load_data  = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the CPU data-memory interface.
// Accepts one request per handshake, checks alignment, runs a gnt/rvalid
// bus transaction and returns a one-cycle response with data or a MIPS
// exception code. Optional bus-error timeout is enabled by LSU_TIMEOUT_EN.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [4:0]  resp_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_sign;
  logic [1:0]  r_addr_lo;

  logic        accept;
  logic        idle;
  logic [1:0]  al_size;
  logic [1:0]  al_addr_lo;
  logic        al_sign;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        tmo_hit;

  assign idle   = (state == S_IDLE);
  assign accept = req_valid & req_ready;

  // One aligner serves both directions: incoming request fields while idle
  // (to register bus outputs), registered fields afterwards (to extract load data).
  assign al_size    = idle ? req_size       : r_size;
  assign al_addr_lo = idle ? req_addr[1:0]  : r_addr_lo;
  assign al_sign    = idle ? req_sign       : r_sign;

  lsu_lane_align u_align (
    .size       (al_size),
    .addr_lo    (al_addr_lo),
    .sign       (al_sign),
    .wdata      (req_wdata),
    .rdata      (mem_rdata),
    .be         (al_be),
    .lane_wdata (al_wdata),
    .load_data  (al_load)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // Cycles spent in S_REQ + S_WAIT since the request was accepted.
  always_ff @(posedge clk) begin
    if (rst)
      tmo_cnt <= '0;
    else if (idle && accept)
      tmo_cnt <= '0;
    else if (state == S_REQ || state == S_WAIT)
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Transaction FSM with registered request, bus and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_exc   <= 1'b0;
      resp_code  <= EXC_NONE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      r_write    <= 1'b0;
      r_size     <= SIZE_BYTE;
      r_sign     <= 1'b0;
      r_addr_lo  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            r_write   <= req_write;
            r_size    <= req_size;
            r_sign    <= req_sign;
            r_addr_lo <= req_addr[1:0];
            if (misaligned(req_size, req_addr[1:0])) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_exc   <= 1'b1;
              resp_code  <= req_write ? EXC_ADES : EXC_ADEL;
              resp_rdata <= '0;
            end else begin
              state     <= S_REQ;
              mem_req   <= 1'b1;
              mem_we    <= req_write;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= al_be;
              mem_wdata <= al_wdata;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (r_write) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_exc   <= 1'b0;
              resp_code  <= EXC_NONE;
              resp_rdata <= '0;
            end else begin
              state <= S_WAIT;
            end
          end else if (tmo_hit) begin
            mem_req    <= 1'b0;
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_exc   <= 1'b1;
            resp_code  <= EXC_DBE;
            resp_rdata <= '0;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_exc   <= 1'b0;
            resp_code  <= EXC_NONE;
            resp_rdata <= al_load;
          end else if (tmo_hit) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_exc   <= 1'b1;
            resp_code  <= EXC_DBE;
            resp_rdata <= '0;
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed vectors push expected
// responses; a monitor pops and compares on every resp_valid.
// Define LSU_TIMEOUT_EN to also exercise the bus-error timeout.
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_exc;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_code;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc), .resp_code(resp_code),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;
  int acc_cyc = 0;

  typedef struct {
    logic        exc;
    logic [4:0]  code;
    logic [31:0] rdata;
    int          at_cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          g;
    int          r;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] bus_wdata;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] res;
    int          lat;
  } vec_t;
  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_exc_code", {26'd0, resp_exc, resp_code}, {26'd0, e.exc, e.code});
          chk("resp_latency", cyc, e.at_cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    if (!req_ready) chk("req_ready_wait", 32'd0, 32'd1);
    req_write = w; req_size = sz; req_sign = sg; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    acc_cyc   = cyc;
    step();
    req_valid = 1'b0;
  endtask

  task automatic push_exp(input logic exc, input logic [4:0] code,
                          input logic [31:0] rdata, input int lat);
    exp_t e;
    e.exc = exc; e.code = code; e.rdata = rdata; e.at_cyc = acc_cyc + lat;
    sb.push_back(e);
  endtask

  task automatic bus_gnt(input int g);
    for (int i = 0; i < g; i++) begin
      chk("mem_req_held", {31'd0, mem_req}, 32'd1);
      step();
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
  endtask

  task automatic bus_rvalid(input int r, input logic [31:0] data);
    for (int i = 0; i < r; i++) step();
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  task automatic wait_resp();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      chk("resp_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_size = 0; req_sign = 0; req_addr = 0; req_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

    //        w  sz    sg addr          wdata         g  r  rdata         be       bus_wdata     exc code rdata         lat
    vecs[0]  = '{1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0,        4'b1111, 32'hDEADBEEF, 0, 0, 32'h0,        2};
    vecs[1]  = '{1, 2'b00, 0, 32'h13, 32'h000000A5, 0, 0, 32'h0,        4'b1000, 32'hA5A5A5A5, 0, 0, 32'h0,        2};
    vecs[2]  = '{0, 2'b00, 1, 32'h12, 32'h0,        0, 0, 32'h12807F00, 4'b0100, 32'h0,        0, 0, 32'hFFFFFF80, 3};
    vecs[3]  = '{0, 2'b01, 0, 32'h12, 32'h0,        0, 0, 32'h12807F00, 4'b1100, 32'h0,        0, 0, 32'h00001280, 3};
    vecs[4]  = '{0, 2'b00, 0, 32'h11, 32'h0,        0, 0, 32'h12807F00, 4'b0010, 32'h0,        0, 0, 32'h0000007F, 3};
    vecs[5]  = '{0, 2'b01, 1, 32'h10, 32'h0,        0, 0, 32'h00008001, 4'b0011, 32'h0,        0, 0, 32'hFFFF8001, 3};
    vecs[6]  = '{0, 2'b10, 0, 32'h04, 32'h0,        0, 0, 32'hCAFEF00D, 4'b1111, 32'h0,        0, 0, 32'hCAFEF00D, 3};
    vecs[7]  = '{0, 2'b10, 0, 32'h06, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        1, 4, 32'h0,        1};
    vecs[8]  = '{1, 2'b01, 0, 32'h01, 32'h1234,     0, 0, 32'h0,        4'b0000, 32'h0,        1, 5, 32'h0,        1};
    vecs[9]  = '{0, 2'b11, 0, 32'h00, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        1, 4, 32'h0,        1};
    vecs[10] = '{1, 2'b11, 0, 32'h00, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        1, 5, 32'h0,        1};
    vecs[11] = '{1, 2'b01, 0, 32'h02, 32'h00001234, 3, 0, 32'h0,        4'b1100, 32'h12341234, 0, 0, 32'h0,        5};
    vecs[12] = '{0, 2'b00, 1, 32'h03, 32'h0,        2, 1, 32'h7F000000, 4'b1000, 32'h0,        0, 0, 32'h0000007F, 6};
    vecs[13] = '{0, 2'b00, 0, 32'h03, 32'h0,        0, 0, 32'h80000000, 4'b1000, 32'h0,        0, 0, 32'h00000080, 3};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_resp", {resp_valid, resp_exc, resp_code, 25'd0}, 32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'd0);
    chk("reset_mem_ctrl", {26'd0, mem_req, mem_we, mem_be}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);

    foreach (vecs[i]) begin
      issue(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata);
      push_exp(vecs[i].exc, vecs[i].code, vecs[i].res, vecs[i].lat);
      if (vecs[i].exc) begin
        chk("misaligned_no_req", {31'd0, mem_req}, 32'd0);
      end else begin
        chk("mem_req", {31'd0, mem_req}, 32'd1);
        chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
        chk("mem_we", {31'd0, mem_we}, {31'd0, vecs[i].w});
        chk("mem_be", {28'd0, mem_be}, {28'd0, vecs[i].be});
        chk("mem_addr", mem_addr, {vecs[i].addr[31:2], 2'b00});
        if (vecs[i].w) chk("mem_wdata", mem_wdata, vecs[i].bus_wdata);
        bus_gnt(vecs[i].g);
        if (!vecs[i].w) bus_rvalid(vecs[i].r, vecs[i].rdata);
      end
      wait_resp();
    end

    // rvalid while idle must not produce a response.
    step();
    bus_rvalid(0, 32'h55555555);
    repeat (3) step();

    // Reset during S_WAIT: transaction abandoned, no response.
    issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    bus_gnt(3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    bus_rvalid(1, 32'hAAAAAAAA);
    repeat (3) step();

    // Normal operation after the mid-transaction reset.
    issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
    push_exp(1'b0, 5'd0, 32'h0BADF00D, 3);
    bus_gnt(0);
    bus_rvalid(0, 32'h0BADF00D);
    wait_resp();

`ifdef LSU_TIMEOUT_EN
    // Load never completes: bus error after TMO cycles in S_REQ/S_WAIT.
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    push_exp(1'b1, 5'd7, 32'h0, TMO + 1);
    bus_gnt(0);
    wait_resp();
    chk("tmo_mem_req", {31'd0, mem_req}, 32'd0);
    bus_rvalid(0, 32'h12345678);
    repeat (3) step();
`endif

    repeat (2) step();
    if (sb.size() != 0) begin
      chk("leftover_expected", sb.size(), 32'd0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "global timeout");
  end

endmodule
